// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - iterative double-dabble binary-to-packed-BCD converter for the score display
module score_bcd_converter #(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_W-1:0]       bin_in,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [3:0]            digit_count,
    output logic                  valid,
    output logic                  busy
);

    localparam int CNT_W = $clog2(IN_W + 1);

    function automatic logic [127:0] pow10(input int n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 128'd10;
        end
        return p;
    endfunction

    if (pow10(DIGITS) <= ((128'd1 << IN_W) - 128'd1)) begin : g_bad_digits
        $error("score_bcd_converter: DIGITS too small for IN_W");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [IN_W-1:0]       snap_q;
    logic [IN_W-1:0]       last_bin_q;
    logic [4*DIGITS-1:0]   scratch_q;
    logic [4*DIGITS-1:0]   scratch_adj;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  prime_q;
    logic [3:0]            msd_count;

    always_comb begin
        scratch_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        msd_count = 4'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] != 4'd0) begin
                msd_count = 4'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((bin_in != last_bin_q) || start || prime_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (bit_cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // snap rotates rather than shifts, so after IN_W steps it holds the
    // converted value again and can be committed as last_bin in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            prime_q     <= 1'b1;
            snap_q      <= '0;
            last_bin_q  <= '0;
            scratch_q   <= '0;
            bit_cnt_q   <= '0;
            bcd_out     <= '0;
            digit_count <= 4'd1;
            valid       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_LOAD: begin
                    snap_q    <= bin_in;
                    scratch_q <= '0;
                    bit_cnt_q <= CNT_W'(IN_W);
                    busy      <= 1'b1;
                end
                S_SHIFT: begin
                    {scratch_q, snap_q} <= {scratch_adj[4*DIGITS-2:0], snap_q, snap_q[IN_W-1]};
                    bit_cnt_q           <= bit_cnt_q - CNT_W'(1);
                end
                S_DONE: begin
                    bcd_out     <= scratch_q;
                    last_bin_q  <= snap_q;
                    digit_count <= msd_count;
                    valid       <= 1'b1;
                    busy        <= 1'b0;
                    prime_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb/tb_score_bcd_converter.sv - scoreboard bench for score_bcd_converter
module tb_score_bcd_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] bin_in;
    logic [39:0] bcd_out;
    logic [3:0]  digit_count;
    logic        valid;
    logic        busy;

    score_bcd_converter #(.IN_W(32), .DIGITS(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bin_in      (bin_in),
        .start       (start),
        .bcd_out     (bcd_out),
        .digit_count (digit_count),
        .valid       (valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] bcd;
        logic [3:0]  dc;
        int          pub_edge;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    int   ecount = 0;
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;
    exp_t sb[$];

    always @(posedge clk) ecount <= ecount + 1;

    function automatic exp_t model(input logic [31:0] v, input int pe);
        exp_t            r;
        longint unsigned x;
        x = 64'(v);
        r.bcd = '0;
        r.dc = 4'd1;
        r.pub_edge = pe;
        for (int i = 0; i < 10; i++) begin
            r.bcd[4*i +: 4] = 4'(x % 10);
            if (x != 0) r.dc = 4'(i + 1);
            x = x / 10;
        end
        return r;
    endfunction

    // Publication = busy falling while out of reset; each one must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_cnt++;
            if (prev_busy && !busy) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_publish bcd_out=%h digit_count=%0d edge=%0d", bcd_out, digit_count, ecount);
                end else begin
                    e = sb.pop_front();
                    if (bcd_out !== e.bcd || digit_count !== e.dc || valid !== 1'b1 || ecount != e.pub_edge) begin
                        errors++;
                        $display("FAIL publish got bcd=%h dc=%0d valid=%b edge=%0d expected bcd=%h dc=%0d valid=1 edge=%0d",
                                 bcd_out, digit_count, valid, ecount, e.bcd, e.dc, e.pub_edge);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    task automatic push(input logic [31:0] v, input int pe);
        sb.push_back(model(v, pe));
    endtask

    task automatic wait_done(input string name, input logic hold_en, input logic [40:0] old);
        logic hold_ok;
        logic timed_out;
        hold_ok = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && !busy) begin
                timed_out = 1'b0;
                break;
            end
            if (hold_en && {valid, bcd_out} !== old) hold_ok = 1'b0;
        end
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL %s_timeout pending=%0d busy=%b required pending=0 busy=0", name, sb.size(), busy);
        end
        if (hold_en) begin
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("FAIL %s_hold output changed early, required valid/bcd held at %h", name, old);
            end
        end
    endtask

    task automatic drive_value(input logic [31:0] v);
        @(posedge clk);
        #1;
        bin_in = v;
        push(v, ecount + 1 + 34);
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bcd_out !== 40'h0 || digit_count !== 4'd1 || valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s got bcd=%h dc=%0d valid=%b busy=%b required bcd=0 dc=1 valid=0 busy=0",
                     name, bcd_out, digit_count, valid, busy);
        end
    endtask

    task automatic check_result(input string name, input logic [39:0] bcd, input logic [3:0] dc);
        checks++;
        if (bcd_out !== bcd || digit_count !== dc) begin
            errors++;
            $display("FAIL %s got bcd=%h dc=%0d required bcd=%h dc=%0d", name, bcd_out, digit_count, bcd, dc);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bin_in = 32'd0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busy_cnt = 0;
        push(32'd0, ecount + 34);
        wait_done("reset_prime", 1'b1, {1'b0, 40'h0});
        checks++;
        if (busy_cnt != 33) begin
            errors++;
            $display("FAIL reset_busy_len got %0d required 33", busy_cnt);
        end
        check_result("reset_prime_result", 40'h0, 4'd1);
    endtask

    task automatic test_change;
        drive_value(32'd1234);
        wait_done("change_1234", 1'b1, {1'b1, 40'h0});
        check_result("change_1234_result", 40'h0000001234, 4'd4);
    endtask

    task automatic test_max;
        drive_value(32'hFFFF_FFFF);
        wait_done("max", 1'b1, {1'b1, 40'h0000001234});
        check_result("max_result", 40'h4294967295, 4'd10);
    endtask

    task automatic test_back_to_back;
        int n;
        @(posedge clk);
        #1;
        bin_in = 32'd100;
        n = ecount + 1;
        push(32'd100, n + 34);
        repeat (5) @(posedge clk);
        #1;
        bin_in = 32'd250;
        push(32'd250, n + 35 + 34);
        wait_done("back_to_back", 1'b0, '0);
        check_result("back_to_back_result", 40'h250, 4'd3);
    endtask

    task automatic test_reset_mid;
        @(posedge clk);
        #1;
        bin_in = 32'd999;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_outputs("reset_mid_async");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(32'd999, ecount + 34);
        wait_done("reset_mid", 1'b1, {1'b0, 40'h0});
        check_result("reset_mid_result", 40'h0000000999, 4'd3);
    endtask

    task automatic test_start;
        drive_value(32'd42);
        wait_done("start_setup", 1'b0, '0);
        check_result("start_setup_result", 40'h42, 4'd2);
        busy_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b1;
        push(32'd42, ecount + 1 + 34);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("start", 1'b1, {1'b1, 40'h42});
        checks++;
        if (busy_cnt != 33) begin
            errors++;
            $display("FAIL start_busy_len got %0d required 33", busy_cnt);
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (busy_cnt != 33 || sb.size() != 0) begin
            errors++;
            $display("FAIL start_dropped busy_cycles=%0d pending=%0d required 33 and 0", busy_cnt, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_change();
        test_max();
        test_back_to_back();
        test_reset_mid();
        test_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
